adjust_ctrl: RTL



---
 rtl/adjust_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adjust_ctrl.sv
// Time-setting controller: button pulses to per-field increment strobes and blink enables.
// Optional ADJ_TIMEOUT_EN builds an inactivity timeout that returns to NORMAL.
module adjust_ctrl #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en1hz,
  input  logic sig2hz,
  input  logic mode,
  input  logic select,
  input  logic adjust,
  output logic sec_inc,
  output logic min_inc,
  output logic hour_inc,
  output logic sec_on,
  output logic min_on,
  output logic hour_on,
  output logic adj_mode
);

  typedef enum logic [1:0] {
    NORMAL,
    ADJ_SEC,
    ADJ_MIN,
    ADJ_HOUR
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [2:0] inc_d;
  logic [2:0] on_d;
  logic btn;

  assign btn = mode | select | adjust;

  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63) begin : g_bad_timeout
  end

`ifdef ADJ_TIMEOUT_EN
  logic [5:0] cnt_q;
  logic [5:0] cnt_d;
  logic       expire;

  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (btn || state_q == NORMAL) begin
      cnt_d = '0;
    end else if (en1hz) begin
      if (cnt_q == 6'(TIMEOUT_SEC - 1)) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic expire;
  logic unused_en1hz;

  assign expire       = 1'b0;
  assign unused_en1hz = en1hz;
`endif

  always_comb begin
    state_d = state_q;
    inc_d   = '0;
    if (mode) begin
      state_d = (state_q == NORMAL) ? ADJ_SEC : NORMAL;
    end else if (state_q != NORMAL) begin
      // increment targets the field selected before this edge
      if (adjust) begin
        unique case (state_q)
          ADJ_SEC:  inc_d = 3'b001;
          ADJ_MIN:  inc_d = 3'b010;
          ADJ_HOUR: inc_d = 3'b100;
          default:  inc_d = '0;
        endcase
      end
      if (select) begin
        unique case (state_q)
          ADJ_SEC:  state_d = ADJ_MIN;
          ADJ_MIN:  state_d = ADJ_HOUR;
          ADJ_HOUR: state_d = ADJ_SEC;
          default:  state_d = state_q;
        endcase
      end else if (expire) begin
        state_d = NORMAL;
      end
    end
  end

  always_comb begin
    on_d = 3'b111;
    unique case (state_d)
      ADJ_SEC:  on_d[0] = sig2hz;
      ADJ_MIN:  on_d[1] = sig2hz;
      ADJ_HOUR: on_d[2] = sig2hz;
      default:  on_d = 3'b111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NORMAL;
      sec_inc  <= 1'b0;
      min_inc  <= 1'b0;
      hour_inc <= 1'b0;
      sec_on   <= 1'b1;
      min_on   <= 1'b1;
      hour_on  <= 1'b1;
      adj_mode <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_inc  <= inc_d[0];
      min_inc  <= inc_d[1];
      hour_inc <= inc_d[2];
      sec_on   <= on_d[0];
      min_on   <= on_d[1];
      hour_on  <= on_d[2];
      adj_mode <= (state_d != NORMAL);
    end
  end

endmodule
